// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back arbiter (ALU vs MEM) feeding the register-file write port, plus a destination scoreboard.
// Latency: accepted write-back drives RegWr/RW/BusW next cycle; its pending bit clears one cycle after that.
// Backpressure: losing source sees Ready low and holds; issue to a pending destination is refused via IssueStall.
module regfile_wb_scheduler #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRd,
    output logic              IssueStall,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              HazardA,
    output logic              HazardB,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluRd,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemRd,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              WbOrphan
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_REG = '1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wbReq_t;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MEM = 1'b1
    } rrState_t;

    rrState_t        rrState;
    rrState_t        rrNext;
    logic            aluGnt;
    logic            memGnt;
    logic            xfer;
    logic            orphanHit;
    logic            issueOk;
    wbReq_t          selReq;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pendingSet;
    logic [NREG-1:0] pendingClr;
    logic [NREG-1:0] pendingNext;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rrState <= RR_MEM;
        end else begin
            rrState <= rrNext;
        end
    end

    // Grant and pointer advance; everything is masked during reset so in-flight requests are dropped.
    always_comb begin
        aluGnt = 1'b0;
        memGnt = 1'b0;
        rrNext = rrState;
        if (!Reset) begin
            if (AluValid && MemValid) begin
                aluGnt = (rrState == RR_ALU);
                memGnt = (rrState == RR_MEM);
            end else begin
                aluGnt = AluValid;
                memGnt = MemValid;
            end
        end
        if (aluGnt) begin
            rrNext = RR_MEM;
        end else if (memGnt) begin
            rrNext = RR_ALU;
        end
    end

    assign AluReady = aluGnt;
    assign MemReady = memGnt;
    assign xfer     = aluGnt | memGnt;

    always_comb begin
        selReq.rd   = AluRd;
        selReq.data = AluData;
        if (memGnt) begin
            selReq.rd   = MemRd;
            selReq.data = MemData;
        end
    end

    assign IssueStall = !Reset && IssueValid && pending[IssueRd];
    assign issueOk    = !Reset && IssueValid && !IssueStall && (IssueRd != ZERO_REG);
    assign HazardA    = !Reset && pending[RA];
    assign HazardB    = !Reset && pending[RB];
    assign orphanHit  = xfer && (selReq.rd != ZERO_REG) && !pending[selReq.rd];

    // Clear follows the registered write port, so the bit drops only once the file holds the value.
    always_comb begin
        pendingSet = '0;
        pendingClr = '0;
        if (issueOk) begin
            pendingSet[IssueRd] = 1'b1;
        end
        if (RegWr) begin
            pendingClr[RW] = 1'b1;
        end
        pendingNext           = (pending & ~pendingClr) | pendingSet;
        pendingNext[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWr    <= 1'b0;
            RW       <= '1;
            BusW     <= '0;
            WbOrphan <= 1'b0;
        end else if (xfer) begin
            RegWr <= (selReq.rd != ZERO_REG);
            RW    <= selReq.rd;
            BusW  <= selReq.data;
            if (orphanHit) begin
                WbOrphan <= 1'b1;
            end
        end else begin
            RegWr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed plus randomized bench for regfile_wb_scheduler against a cycle-level reference model.
module tb_regfile_wb_scheduler;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        IssueValid;
    logic [4:0]  IssueRd;
    logic        IssueStall;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic        HazardA;
    logic        HazardB;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [63:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [4:0]  MemRd;
    logic [63:0] MemData;
    logic        MemReady;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        WbOrphan;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mPend[32];
    bit          mRrMem;
    bit          mRegWr;
    logic [4:0]  mRW;
    logic [63:0] mBusW;
    bit          mOrphan;
    bit          mAluG;
    bit          mMemG;

    regfile_wb_scheduler #(.DATA_W(64), .ADDR_W(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .IssueValid(IssueValid), .IssueRd(IssueRd), .IssueStall(IssueStall),
        .RA(RA), .RB(RB), .HazardA(HazardA), .HazardB(HazardB),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
        .RegWr(RegWr), .RW(RW), .BusW(BusW), .WbOrphan(WbOrphan)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
        mRrMem  = 1'b1;
        mRegWr  = 1'b0;
        mRW     = 5'd31;
        mBusW   = 64'd0;
        mOrphan = 1'b0;
    endtask

    // One clock: predict combinational outputs from current inputs, check everything at negedge,
    // then advance the model at the rising edge.
    task automatic cycle();
        bit          eAlu, eMem, eStall, eHa, eHb;
        bit          old[32];
        logic [4:0]  rd;
        logic [63:0] data;
        eAlu = 1'b0;
        eMem = 1'b0;
        if (!Reset) begin
            if (AluValid && MemValid) begin
                if (mRrMem) eMem = 1'b1;
                else        eAlu = 1'b1;
            end else begin
                eAlu = AluValid;
                eMem = MemValid;
            end
        end
        eStall = !Reset && IssueValid && mPend[IssueRd];
        eHa    = !Reset && mPend[RA];
        eHb    = !Reset && mPend[RB];
        @(negedge Clk);
        chk("AluReady", {63'd0, AluReady}, {63'd0, eAlu});
        chk("MemReady", {63'd0, MemReady}, {63'd0, eMem});
        chk("IssueStall", {63'd0, IssueStall}, {63'd0, eStall});
        chk("HazardA", {63'd0, HazardA}, {63'd0, eHa});
        chk("HazardB", {63'd0, HazardB}, {63'd0, eHb});
        chk("RegWr", {63'd0, RegWr}, {63'd0, mRegWr});
        chk("RW", {59'd0, RW}, {59'd0, mRW});
        chk("BusW", BusW, mBusW);
        chk("WbOrphan", {63'd0, WbOrphan}, {63'd0, mOrphan});
        @(posedge Clk);
        if (Reset) begin
            modelReset();
        end else begin
            old = mPend;
            if (mRegWr) mPend[mRW] = 1'b0;
            if (IssueValid && !eStall && IssueRd != 5'd31) mPend[IssueRd] = 1'b1;
            if (eAlu || eMem) begin
                rd   = eAlu ? AluRd : MemRd;
                data = eAlu ? AluData : MemData;
                if (rd != 5'd31 && !old[rd]) mOrphan = 1'b1;
                mRegWr = (rd != 5'd31);
                mRW    = rd;
                mBusW  = data;
                mRrMem = eAlu;
            end else begin
                mRegWr = 1'b0;
            end
        end
        mAluG = eAlu;
        mMemG = eMem;
        #1;
    endtask

    // Mostly target registers that are pending so orphans stay occasional.
    function automatic logic [4:0] pickRd();
        logic [4:0] list[$];
        for (int i = 0; i < 31; i++) if (mPend[i]) list.push_back(5'(i));
        if (list.size() != 0 && $urandom_range(0, 3) != 0)
            return list[$urandom_range(0, list.size() - 1)];
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        int mi;
        int ai;
        Reset = 1'b1;
        IssueValid = 1'b0; IssueRd = 5'd0;
        RA = 5'd0; RB = 5'd0;
        AluValid = 1'b1; AluRd = 5'd1; AluData = 64'h1111;
        MemValid = 1'b1; MemRd = 5'd2; MemData = 64'h2222;
        @(posedge Clk);
        #1;
        modelReset();

        // Reset held two cycles with both sources requesting
        cycle();
        cycle();
        chk("rst_regwr", {63'd0, RegWr}, 64'd0);
        chk("rst_rw", {59'd0, RW}, 64'h1f);
        chk("rst_busw", BusW, 64'd0);
        Reset = 1'b0;
        #1;
        chk("first_mem_grant", {63'd0, MemReady}, 64'd1);
        chk("first_alu_grant", {63'd0, AluReady}, 64'd0);
        AluValid = 1'b0; MemValid = 1'b0;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;

        // Single ALU write-back to r5
        RA = 5'd5; RB = 5'd6;
        IssueValid = 1'b1; IssueRd = 5'd5;
        cycle();
        IssueValid = 1'b0;
        chk("hazA_after_issue", {63'd0, HazardA}, 64'd1);
        AluValid = 1'b1; AluRd = 5'd5; AluData = 64'hDEADBEEF_00000001;
        #1;
        chk("alu_ready", {63'd0, AluReady}, 64'd1);
        cycle();
        AluValid = 1'b0;
        chk("wb_regwr", {63'd0, RegWr}, 64'd1);
        chk("wb_rw", {59'd0, RW}, 64'd5);
        chk("wb_busw", BusW, 64'hDEADBEEF_00000001);
        chk("hazA_still", {63'd0, HazardA}, 64'd1);
        cycle();
        chk("hazA_cleared", {63'd0, HazardA}, 64'd0);

        // Contention: MEM writes 1,3,5 and ALU writes 2,4,6
        for (int i = 1; i <= 6; i++) begin
            IssueValid = 1'b1; IssueRd = 5'(i);
            cycle();
        end
        IssueValid = 1'b0;
        mi = 0; ai = 0;
        for (int i = 0; i < 6; i++) begin
            MemValid = (mi < 3); MemRd = 5'(2 * mi + 1); MemData = 64'hA000_0000_0000_0000 | 64'(2 * mi + 1);
            AluValid = (ai < 3); AluRd = 5'(2 * ai + 2); AluData = 64'hB000_0000_0000_0000 | 64'(2 * ai + 2);
            #1;
            if (i % 2 == 0) chk("cont_mem_grant", {63'd0, MemReady}, 64'd1);
            else            chk("cont_alu_grant", {63'd0, AluReady}, 64'd1);
            cycle();
            if (i % 2 == 0) mi++;
            else            ai++;
            chk("cont_rw", {59'd0, RW}, 64'(i + 1));
        end
        MemValid = 1'b0; AluValid = 1'b0;
        cycle();
        cycle();

        // Zero register
        IssueValid = 1'b1; IssueRd = 5'd31;
        #1;
        chk("zero_no_stall", {63'd0, IssueStall}, 64'd0);
        cycle();
        IssueValid = 1'b0;
        RA = 5'd31;
        #1;
        chk("zero_no_pending", {63'd0, HazardA}, 64'd0);
        MemValid = 1'b1; MemRd = 5'd31; MemData = 64'h3131;
        #1;
        chk("zero_mem_ready", {63'd0, MemReady}, 64'd1);
        cycle();
        MemValid = 1'b0;
        chk("zero_regwr", {63'd0, RegWr}, 64'd0);
        chk("zero_orphan", {63'd0, WbOrphan}, 64'd0);
        cycle();

        // Double issue to r7
        IssueValid = 1'b1; IssueRd = 5'd7;
        cycle();
        #1;
        chk("dbl_stall_1", {63'd0, IssueStall}, 64'd1);
        cycle();
        AluValid = 1'b1; AluRd = 5'd7; AluData = 64'h7777;
        cycle();
        AluValid = 1'b0;
        chk("dbl_wb_rw", {59'd0, RW}, 64'd7);
        chk("dbl_stall_same_cycle_clear", {63'd0, IssueStall}, 64'd1);
        cycle();
        chk("dbl_stall_released", {63'd0, IssueStall}, 64'd0);
        cycle();
        IssueValid = 1'b0;
        RA = 5'd7;
        #1;
        chk("dbl_reissued_pending", {63'd0, HazardA}, 64'd1);
        AluValid = 1'b1; AluRd = 5'd7; AluData = 64'h7778;
        cycle();
        AluValid = 1'b0;
        cycle();
        cycle();

        // Orphan write-back to r9
        RA = 5'd9;
        #1;
        chk("orph_not_pending", {63'd0, HazardA}, 64'd0);
        AluValid = 1'b1; AluRd = 5'd9; AluData = 64'h9999;
        cycle();
        AluValid = 1'b0;
        chk("orph_regwr", {63'd0, RegWr}, 64'd1);
        chk("orph_flag", {63'd0, WbOrphan}, 64'd1);
        cycle();
        cycle();
        cycle();
        chk("orph_sticky", {63'd0, WbOrphan}, 64'd1);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("orph_cleared", {63'd0, WbOrphan}, 64'd0);

        // Randomized traffic; sources hold their request until granted
        for (int n = 0; n < 600; n++) begin
            if (mAluG || !AluValid) begin
                AluValid = 1'($urandom_range(0, 1));
                AluRd    = pickRd();
                AluData  = {$urandom, $urandom};
            end
            if (mMemG || !MemValid) begin
                MemValid = 1'($urandom_range(0, 1));
                MemRd    = pickRd();
                MemData  = {$urandom, $urandom};
            end
            IssueValid = 1'($urandom_range(0, 1));
            IssueRd    = 5'($urandom_range(0, 31));
            RA         = 5'($urandom_range(0, 31));
            RB         = 5'($urandom_range(0, 31));
            Reset      = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32 x 64-bit register file (X31 hard-wired zero, writes on the falling edge of `Clk`). Shares the register file's single write port between two result sources, the ALU and the memory unit, using round-robin arbitration. Tracks in-flight destination registers so decode can detect read-after-write hazards on the two read ports. Sits between the execute/memory stages and the register file write port (`RegWr`, `RW`, `BusW`).

## Interface
Parameters:
- `DATA_W`, 64, write-back data width
- `ADDR_W`, 5, register address width; register `2**ADDR_W-1` is the zero register

Ports:
- `Clk`  input  1  clock; all state updates on the rising edge
- `Reset`  input  1  synchronous, active-high reset
- `IssueValid`  input  1  decode issues an instruction that will write `IssueRd`
- `IssueRd`  input  ADDR_W  destination of the issued instruction
- `IssueStall`  output  1  issue refused this cycle; decode must hold
- `RA`, `RB`  input  ADDR_W  read addresses currently presented to the register file
- `HazardA`, `HazardB`  output  1  `RA` / `RB` has a pending write
- `AluValid`, `AluRd`, `AluData`  input  1 / ADDR_W / DATA_W  ALU write-back request
- `AluReady`  output  1  ALU request accepted this cycle
- `MemValid`, `MemRd`, `MemData`  input  1 / ADDR_W / DATA_W  memory write-back request
- `MemReady`  output  1  memory request accepted this cycle
- `RegWr`, `RW`, `BusW`  output  1 / ADDR_W / DATA_W  registered drive to the register file write port
- `WbOrphan`  output  1  sticky: a write-back arrived for a non-pending, non-zero register

## Operation
- Arbitration is combinational from the inputs and the `rr` pointer. If only one source is valid, that source is granted. If both are valid, the source named by `rr` is granted. At most one grant per cycle.
- `AluReady` and `MemReady` equal the grant. A source must hold `Valid`, `Rd` and `Data` stable until it sees `Ready`. The transfer completes on the rising edge where `Valid && Ready`.
- `rr` updates on every completed transfer to point at the other source. Reset value: MEM.
- On a transfer, the output register loads `RW <= Rd` and `BusW <= Data`. It loads `RegWr <= 1`, except when `Rd` is the zero register, in which case `RegWr <= 0`. With no transfer, `RegWr <= 0` and `RW`/`BusW` hold.
- Scoreboard is a `2**ADDR_W`-bit `pending` vector. The zero register bit is constantly 0.
  - Set: `IssueValid && !IssueStall`.
  - Clear: at the rising edge that ends a cycle with `RegWr == 1`, for bit `RW`.
  - If set and clear target the same bit on the same edge, set wins.
- `IssueStall = IssueValid && pending[IssueRd]`, evaluated on current `pending` only. A same-cycle clear does not unblock the issue. Issue to the zero register never stalls and sets nothing.
- `HazardA = pending[RA]` and `HazardB = pending[RB]`, combinational.
- `WbOrphan` is set on a transfer whose `Rd` is non-zero and not pending. The write is still performed. The flag clears only on `Reset`.

## Timing
- Reset values: `RegWr=0`, `RW=all ones`, `BusW=0`, `WbOrphan=0`, `pending=0`, `rr=MEM`.
- `AluReady`, `MemReady`, `IssueStall`, `HazardA` and `HazardB` are forced to 0 while `Reset` is high. A request in flight during reset is dropped and must be re-presented.
- Transfer at rising edge k:
  - `RegWr`/`RW`/`BusW` are valid throughout cycle k+1.
  - The register file captures the value at the falling edge inside cycle k+1.
  - The pending bit clears at edge k+2, so `HazardX` deasserts in cycle k+2, when the register file already holds the new value.
- Issue latency: pending becomes visible one cycle after issue.
- Throughput: one write-back per cycle. Under continuous dual requests, grants strictly alternate.

## Test plan
- Reset: hold `Reset` 2 cycles with both sources valid → all outputs at reset values and no Ready seen; first cycle after reset with both valid → MEM granted.
- Single ALU write-back: issue Rd=5, then ALU writes 5 / `0xDEADBEEF_00000001` → `HazardA` (RA=5) high from the issue+1 cycle; `RegWr=1`, `RW=5` one cycle after accept; `HazardA` low two cycles after accept.
- Contention: both sources valid for 6 cycles with Rd=1..6 → grants alternate MEM, ALU, MEM, …; `RW` sequence matches; no lost or duplicated writes.
- Zero register: issue Rd=31, then MEM write-back to 31 → no stall, no pending, `MemReady=1`, `RegWr` stays 0, `WbOrphan` stays 0.
- Double issue: issue Rd=7, then issue Rd=7 again before write-back → second issue sees `IssueStall=1` until the edge after `RegWr` for 7, then it is accepted.
- Orphan: ALU writes Rd=9 with nothing pending → write performed and `WbOrphan` latches 1 until `Reset`.
